// File: rtl/audio_decimator.sv
// rtl/audio_decimator.sv - accumulate-and-dump decimating averager ahead of the audio PWM stage
//
// Averages 2^k consecutive offset-binary samples and emits one floor-averaged
// sample per window. The output is held between updates.
//
// Ports:
//   clk        system clock
//   reset      synchronous reset, active-low
//   in_valid   qualifies in_sample for one clk
//   in_sample  input sample, unsigned offset-binary
//   rate_sel   k = log2 of decimation factor (clamped to MAX_LOG2N)
//   out_sample registered averaged sample, held between updates
//   out_valid  one-clk pulse when out_sample updates
//   busy       high while a window is partially filled

module audio_decimator #(
  parameter int WIDTH     = 8,
  parameter int MAX_LOG2N = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_sample,
  input  logic [2:0]       rate_sel,
  output logic [WIDTH-1:0] out_sample,
  output logic             out_valid,
  output logic             busy
);

  localparam int AW = WIDTH + MAX_LOG2N;
  localparam int CW = (MAX_LOG2N > 0) ? MAX_LOG2N : 1;

  logic [3:0]    rate_ext;
  logic [2:0]    rate_clamped;
  logic [2:0]    k_q;
  logic [AW-1:0] acc;
  logic [AW-1:0] sum;
  logic [CW-1:0] count;
  logic [CW-1:0] last_count;
  logic          dump;

  // Widened before comparing so the clamp stays meaningful for any MAX_LOG2N.
  always_comb begin
    rate_ext = {1'b0, rate_sel};
    if (rate_ext > 4'(MAX_LOG2N)) begin
      rate_clamped = 3'(MAX_LOG2N);
    end else begin
      rate_clamped = rate_sel;
    end
  end

  // The sum includes the sample being presented, so the dump result covers
  // all N samples of the window without an extra cycle.
  assign sum        = acc + AW'(in_sample);
  assign last_count = CW'((32'd1 << k_q) - 32'd1);
  assign dump       = in_valid && (count == last_count);
  assign busy       = (count != '0);

  always_ff @(posedge clk) begin
    if (!reset) begin
      acc        <= '0;
      count      <= '0;
      k_q        <= rate_clamped;
      out_sample <= WIDTH'(1 << (WIDTH - 1));
      out_valid  <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (dump) begin
        out_sample <= WIDTH'(sum >> k_q);
        out_valid  <= 1'b1;
        acc        <= '0;
        count      <= '0;
        // Rate changes take effect only at a window boundary.
        k_q        <= rate_clamped;
      end else if (in_valid) begin
        acc   <= sum;
        count <= count + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_audio_decimator.sv
// tb/tb_audio_decimator.sv - directed self-checking bench for audio_decimator

module tb_audio_decimator;

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic [7:0] in_sample;
  logic [2:0] rate_sel;
  logic [7:0] out_sample;
  logic       out_valid;
  logic       busy;

  int n_compared;
  int n_mismatched;

  audio_decimator #(.WIDTH(8), .MAX_LOG2N(7)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_sample  (in_sample),
    .rate_sel   (rate_sel),
    .out_sample (out_sample),
    .out_valid  (out_valid),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_compared++;
    if (obs !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present one input for one clock; outputs are sampled 1 ns after the edge.
  task automatic present(input logic v, input logic [7:0] s);
    in_valid  = v;
    in_sample = s;
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input int ov, input int os, input int bz);
    check({tag, ".out_valid"}, int'(out_valid), ov);
    check({tag, ".out_sample"}, int'(out_sample), os);
    check({tag, ".busy"}, int'(busy), bz);
  endtask

  logic [7:0] vals [3];

  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    reset     = 1'b0;
    in_valid  = 1'b0;
    in_sample = 8'h00;
    rate_sel  = 3'd2;

    // Reset, then idle for 10 cycles
    repeat (3) present(1'b0, 8'h00);
    check_out("reset", 0, 8'h80, 0);
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      present(1'b0, 8'h00);
      check_out("idle", 0, 8'h80, 0);
    end

    // k=2: 0x10+0x20+0x30+0x41 = 0xA1, >>2 = 0x28
    present(1'b1, 8'h10); check_out("k2_s1", 0, 8'h80, 1);
    present(1'b1, 8'h20); check_out("k2_s2", 0, 8'h80, 1);
    present(1'b1, 8'h30); check_out("k2_s3", 0, 8'h80, 1);
    present(1'b1, 8'h41); check_out("k2_dump", 1, 8'h28, 0);
    present(1'b0, 8'h00); check_out("k2_hold", 0, 8'h28, 0);

    // k=7 via reset: 128 x 0xFF with in_valid toggling
    rate_sel = 3'd7;
    reset    = 1'b0;
    present(1'b0, 8'h00);
    check_out("rst7", 0, 8'h80, 0);
    reset = 1'b1;
    for (int i = 0; i < 128; i++) begin
      if (i == 127) rate_sel = 3'd0;
      present(1'b1, 8'hFF);
      if (i < 127) begin
        check("k7_mid.out_valid", int'(out_valid), 0);
        check("k7_mid.busy", int'(busy), 1);
      end else begin
        check_out("k7_dump", 1, 8'hFF, 0);
      end
      present(1'b0, 8'h00);
      check("k7_gap.out_valid", int'(out_valid), 0);
    end
    check("k7_hold.out_sample", int'(out_sample), 8'hFF);

    // k=0: every valid sample passes straight through
    vals[0] = 8'h00; vals[1] = 8'h7F; vals[2] = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) rate_sel = 3'd1;
      present(1'b1, vals[i]);
      check_out("k0_pass", 1, int'(vals[i]), 0);
    end
    present(1'b0, 8'h00);
    check_out("k0_idle", 0, 8'hFF, 0);

    // k=1 window; rate_sel changed mid-window does not affect it
    present(1'b1, 8'h40); check_out("k1_s1", 0, 8'hFF, 1);
    rate_sel = 3'd3;
    present(1'b1, 8'h60); check_out("k1_dump", 1, 8'h50, 0);

    // Now k=3: samples 1..8 sum 36, >>3 = 4
    for (int i = 1; i <= 8; i++) begin
      present(1'b1, 8'(i));
      if (i < 8) check_out("k3_mid", 0, 8'h50, 1);
      else       check_out("k3_dump", 1, 8'h04, 0);
    end

    // 3 samples into a k=3 window, then reset (with in_valid high) for 1 cycle
    for (int i = 0; i < 3; i++) begin
      present(1'b1, 8'hF0);
      check_out("pre_rst", 0, 8'h04, 1);
    end
    reset = 1'b0;
    present(1'b1, 8'hFF);
    check_out("mid_rst", 0, 8'h80, 0);
    reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      present(1'b1, 8'h20);
      if (i < 7) check_out("post_rst_mid", 0, 8'h80, 1);
      else       check_out("post_rst_dump", 1, 8'h20, 0);
    end
    present(1'b0, 8'h00);
    check_out("post_rst_hold", 0, 8'h20, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/audio_decimator.md
Name: audio_decimator

Overview:
- Accumulate-and-dump decimating low-pass stage between the demodulator output and the Audio PWM block.
- Averages N = 2^k consecutive 8-bit offset-binary samples (midscale 0x80 = silence) and emits one averaged sample per window.
- Holds the averaged value steady for the PWM stage between updates.
- Removes carrier-rate ripple from the demodulated signal before audio output.

Parameters:
WIDTH, 8, sample width in bits (unsigned offset-binary)
MAX_LOG2N, 7, largest supported log2 decimation factor; accumulator width = WIDTH+MAX_LOG2N

Ports:
clk  input  1  system clock (100 MHz domain)
reset  input  1  synchronous reset, active-low: sampled on rising edge of clk, block held in reset while 0
in_valid  input  1  qualifies in_sample for one clk
in_sample  input  WIDTH  input sample, unsigned offset-binary
rate_sel  input  3  k = log2 of decimation factor, N = 2^k (0..7; values > MAX_LOG2N clamp to MAX_LOG2N)
out_sample  output  WIDTH  registered averaged sample, held between updates
out_valid  output  1  one-clk pulse when out_sample updates
busy  output  1  high while a window is partially filled (count != 0)

Behaviour:
- Reset (reset==0 at rising edge):
  - acc=0, count=0, out_sample=2^(WIDTH-1) (0x80), out_valid=0, busy=0.
  - k_q <= clamp(rate_sel).
  - Reset has priority over every other event; reset mid-window discards the partial sum, no output pulse.
- k_q latching: k_q is the latched decimation exponent, updated only at reset and at each dump edge (from current rate_sel). rate_sel changes mid-window do not affect the current window.
- in_valid==0: acc, count, out_sample hold; out_valid=0.
- in_valid==1 and count != N-1 (N = 2^k_q):
  - acc <= acc + in_sample; count <= count+1.
- in_valid==1 and count == N-1 (dump):
  - out_sample <= (acc + in_sample) >> k_q (floor, truncation).
  - out_valid <= 1 for exactly this next cycle.
  - acc <= 0; count <= 0; k_q <= clamp(rate_sel).
- Latency: out_sample/out_valid update on the clk edge that captures the N-th valid sample; visible one cycle after that sample is presented.
- k_q==0: every valid sample is a dump; out_sample = in_sample registered, out_valid mirrors in_valid delayed one cycle.
- Width rules: acc is WIDTH+MAX_LOG2N bits; max sum 255*128 fits with no overflow. Result is always ≤ 2^WIDTH-1, so no saturation is needed.
- Back-to-back windows: a dump cycle with in_valid==1 consumes that sample as the last of the current window. The next window starts empty; no sample is dropped or double-counted.
- busy = (count != 0), registered.
- out_valid is never high for two consecutive cycles unless k_q==0 and in_valid is continuously high.

Test Plan:
- Reset release, no in_valid for 10 cycles -> out_sample=0x80, out_valid=0, busy=0 throughout.
- rate_sel=2, in_valid=1 continuous, samples 0x10,0x20,0x30,0x41 -> one out_valid pulse after 4th sample, out_sample=0x28 (0xA1>>2 floor). busy high cycles 2-4.
- rate_sel=7, 128 samples of 0xFF with in_valid toggling 1/0 -> single pulse after 128th valid sample, out_sample=0xFF, no overflow.
- rate_sel=0, samples 0x00,0x7F,0xFF on consecutive cycles -> out_valid high 3 cycles, out_sample follows each value with 1-cycle latency.
- rate_sel=1 window started (1 sample 0x40), rate_sel switched to 3 -> current window completes after 2nd sample 0x60 giving 0x50. Next window needs 8 samples.
- 3 samples into a rate_sel=3 window, reset asserted 1 cycle -> acc/count cleared, out_sample=0x80, no out_valid; next 8 samples of 0x20 -> out_sample=0x20.
